// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit and the multi-cycle multiply/divide unit.
// The control unit drives the request and the unit answers through the slave modport.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 op;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [2*WIDTH-1:0]   z_out;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, op, a_in, b_in,
        input  z_out, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output z_out, busy, done, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// The result is written to the Z register as {high/remainder, low/quotient}.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           clear,
    mul_div_unit_if.slave  bus
);
    // state    | meaning
    // S_IDLE   | waiting for start; done pulses here after FINISH
    // S_CALC   | one Booth / restoring iteration per cycle, WIDTH cycles
    // S_FINISH | sign fix-up and result register load
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_a, r_b, r_hi, r_lo;
    logic                 r_q, r_op, r_dz;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_z;
    logic                 r_done, r_dz_out;
    logic                 w_busy;
    logic [WIDTH:0]       w_sum, w_trial;
    logic [WIDTH-1:0]     w_mag_b, w_quo, w_rem;
    logic                 w_a_neg, w_b_neg;

    assign w_a_neg = r_a[WIDTH-1];
    assign w_b_neg = r_b[WIDTH-1];
    assign w_mag_b = w_b_neg ? -r_b : r_b;

    // Booth add/subtract is done one bit wider so subtracting the most negative A cannot overflow.
    always_comb begin
        w_sum = {r_hi[WIDTH-1], r_hi};
        case ({r_lo[0], r_q})
            2'b01:   w_sum = {r_hi[WIDTH-1], r_hi} + {r_a[WIDTH-1], r_a};
            2'b10:   w_sum = {r_hi[WIDTH-1], r_hi} - {r_a[WIDTH-1], r_a};
            default: w_sum = {r_hi[WIDTH-1], r_hi};
        endcase
    end

    assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, w_mag_b};
    assign w_quo   = (w_a_neg ^ w_b_neg) ? -r_lo : r_lo;
    assign w_rem   = w_a_neg ? -r_hi : r_hi;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (bus.op && (bus.b_in == '0)) ? S_FINISH : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(WIDTH-1))
                    w_next = S_FINISH;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_q      <= 1'b0;
            r_op     <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_z      <= '0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a_in;
                        r_b   <= bus.b_in;
                        r_op  <= bus.op;
                        r_dz  <= bus.op && (bus.b_in == '0);
                        r_cnt <= '0;
                        r_hi  <= '0;
                        r_q   <= 1'b0;
                        r_lo  <= bus.op ? (bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in) : bus.b_in;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_op) begin
                        r_hi <= w_sum[WIDTH:1];
                        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                        r_q  <= r_lo[0];
                    end else if (!w_trial[WIDTH]) begin
                        r_hi <= w_trial[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FINISH: begin
                    r_dz_out <= r_dz;
                    if (r_dz)       r_z <= {r_a, {WIDTH{1'b1}}};
                    else if (!r_op) r_z <= {r_hi, r_lo};
                    else            r_z <= {w_rem, w_quo};
                end
                default: ;
            endcase
        end
    end

    assign bus.z_out       = r_z;
    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dz_out;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycles, busy_cnt, done_cnt;
    logic [63:0] z_obs;
    logic        dz_obs;
    logic [31:0] ra, rb;
    logic        rop;

    mul_div_unit_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_z(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            p = sa * sb;
            return 64'(p);
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; drives start and waits (bounded) for done.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cycles = 1; busy_cnt = 0;
        while (!bus.done && cycles < 100) begin
            if (bus.busy) busy_cnt++;
            @(posedge clock); #1;
            cycles++;
        end
        z_obs  = bus.z_out;
        dz_obs = bus.div_by_zero;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
        #12;
        check("reset_z", bus.z_out, 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dz", 64'(bus.div_by_zero), 64'd0);
        clear = 1'b1;
        @(posedge clock); #1;

        run_op(1'b0, 32'd7, -32'sd3);
        check("mul7x-3_z", z_obs, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul7x-3_latency", 64'(cycles), 64'd34);
        check("mul7x-3_busy_cycles", 64'(busy_cnt), 64'd33);
        check("mul7x-3_dz", 64'(dz_obs), 64'd0);
        @(posedge clock); #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("z_holds", bus.z_out, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(1'b1, -32'sd17, 32'd5);
        check("div-17/5_z", z_obs, {32'hFFFF_FFFE, 32'hFFFF_FFFD});
        check("div-17/5_dz", 64'(dz_obs), 64'd0);

        // Back-to-back: the next start is driven while done is still high.
        run_op(1'b1, 32'd100, 32'd0);
        check("div100/0_z", z_obs, {32'd100, 32'hFFFF_FFFF});
        check("div100/0_latency", 64'(cycles), 64'd2);
        check("div100/0_dz", 64'(dz_obs), 64'd1);

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        check("mul_min_min_z", z_obs, 64'h4000_0000_0000_0000);
        check("b2b_latency", 64'(cycles), 64'd34);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min/-1_z", z_obs, {32'd0, 32'h8000_0000});
        check("div_min/-1_dz", 64'(dz_obs), 64'd0);

        // Second start mid-CALC with changed operands must be ignored.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd123; bus.b_in = -32'sd456;
        @(posedge clock); #1;
        bus.start = 1'b0; cycles = 1;
        repeat (4) begin @(posedge clock); #1; cycles++; end
        bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'd999; bus.b_in = 32'd1;
        @(posedge clock); #1;
        bus.start = 1'b0; cycles++;
        while (!bus.done && cycles < 100) begin @(posedge clock); #1; cycles++; end
        check("ignore_start_z", bus.z_out, ref_z(1'b0, 32'd123, -32'sd456));
        check("ignore_start_latency", 64'(cycles), 64'd34);
        done_cnt = 0;
        repeat (40) begin @(posedge clock); #1; if (bus.done) done_cnt++; end
        check("ignore_start_no_second_done", 64'(done_cnt), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 6 == 0)      rb = 32'd0;
            else if (i % 4 == 1) rb = 32'(int'($urandom_range(0, 16)) - 8);
            if (i % 5 == 2)      ra = 32'(int'($urandom_range(0, 64)) - 32);
            run_op(rop, ra, rb);
            check($sformatf("rand%0d_op%0d_z", i, rop), z_obs, ref_z(rop, ra, rb));
            check($sformatf("rand%0d_dz", i), 64'(dz_obs), 64'(rop && (rb == 32'd0)));
            check($sformatf("rand%0d_latency", i), 64'(cycles),
                  (rop && (rb == 32'd0)) ? 64'd2 : 64'd34);
        end

        // Leave div_by_zero set so the abort visibly clears it.
        run_op(1'b1, 32'd55, 32'd0);
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'd1000; bus.b_in = 32'd1000;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        clear = 1'b0;
        #1;
        check("abort_z", bus.z_out, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_dz", 64'(bus.div_by_zero), 64'd0);
        repeat (3) @(posedge clock);
        #1 clear = 1'b1;
        done_cnt = 0;
        repeat (40) begin @(posedge clock); #1; if (bus.done) done_cnt++; end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        run_op(1'b0, 32'd6, 32'd7);
        check("post_reset_mul6x7_z", z_obs, 64'd42);
        check("post_reset_latency", 64'(cycles), 64'd34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
